// File: rtl/candy_wb_arbiter_pkg.sv
// Shared widths, zero constants and the round-robin selector type for the writeback arbiter.
// Register widths come from the existing CANDY_REG_ADDR_W / CANDY_REG_DATA_W macros when defined.
`ifndef CANDY_REG_ADDR_W
`define CANDY_REG_ADDR_W 5
`endif
`ifndef CANDY_REG_DATA_W
`define CANDY_REG_DATA_W 32
`endif

package candy_wb_arbiter_pkg;

    localparam int REG_ADDR_W = `CANDY_REG_ADDR_W;
    localparam int REG_DATA_W = `CANDY_REG_DATA_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/candy_rr_arb2.sv
// Two-way round-robin arbiter: grants the lone valid requester, or the preferred one on contention.
module candy_rr_arb2
    import candy_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    rr_sel_e rr;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (rr == RR_REQ1) ? 2'b10 : 2'b01;
        end
    end

    // After a transfer the requester that lost (or was absent) gets priority next time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= RR_REQ0;
        end else if (advance) begin
            rr <= grant[0] ? RR_REQ1 : RR_REQ0;
        end
    end

endmodule

// File: rtl/candy_wb_arbiter.sv
// Register-file writeback arbiter (ALU vs load path) with decode read-hazard stall.
// Optional saturating contention counter enabled by CANDY_WB_CONFLICT_CNT_EN.
module candy_wb_arbiter
    import candy_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
`ifdef CANDY_WB_CONFLICT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              stall_o
`ifdef CANDY_WB_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(ZERO_ADDR);
    localparam logic [DATA_W-1:0] WORD_ZERO = DATA_W'(ZERO_WORD);

    logic [1:0]        grant;
    logic              xfer;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winData;
    logic              pend0;
    logic              pend1;
    logic              hit1;
    logic              hit2;

    candy_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    assign xfer       = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign winAddr    = grant[1] ? req1_addr : req0_addr;
    assign winData    = grant[1] ? req1_data : req0_data;

    // Writes to r0 are consumed but never enabled; address/data still follow the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_o    <= 1'b0;
            waddr_o <= ADDR_ZERO;
            wdata_o <= WORD_ZERO;
        end else if (xfer) begin
            we_o    <= (winAddr != ADDR_ZERO);
            waddr_o <= winAddr;
            wdata_o <= winData;
        end else begin
            we_o    <= 1'b0;
        end
    end

    // Only requests still waiting stall decode; this cycle's winner is covered by the bypass.
    always_comb begin
        pend0   = req0_valid & ~grant[0];
        pend1   = req1_valid & ~grant[1];
        hit1    = re1 && (raddr1 != ADDR_ZERO) &&
                  ((pend0 && (req0_addr == raddr1)) || (pend1 && (req1_addr == raddr1)));
        hit2    = re2 && (raddr2 != ADDR_ZERO) &&
                  ((pend0 && (req0_addr == raddr2)) || (pend1 && (req1_addr == raddr2)));
        stall_o = hit1 | hit2;
    end

`ifdef CANDY_WB_CONFLICT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (req0_valid && req1_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_candy_wb_arbiter.sv
// Randomized self-checking bench for candy_wb_arbiter against a cycle-level behavioural model.
// Also checks conflict_cnt when CANDY_WB_CONFLICT_CNT_EN is defined.
module tb_candy_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;
    logic          re1, re2;
    logic [AW-1:0] raddr1, raddr2;
    logic          stall_o;
`ifdef CANDY_WB_CONFLICT_CNT_EN
    logic [CW-1:0] conflict_cnt;
`endif

    candy_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .re1          (re1),
        .raddr1       (raddr1),
        .re2          (re2),
        .raddr2       (raddr2),
        .stall_o      (stall_o)
`ifdef CANDY_WB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Model: who is preferred on contention, and what the write port should show this cycle.
    int            mPrefer;
    logic          mWe;
    logic [AW-1:0] mWaddr;
    logic [DW-1:0] mWdata;
    bit            mHoldKnown;
    int            mCnt;

    // Pending requests held by the random requesters until accepted.
    logic          p0v, p1v;
    logic [AW-1:0] p0a, p1a;
    logic [DW-1:0] p0d, p1d;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPrefer    = 0;
        mWe        = 1'b0;
        mWaddr     = '0;
        mWdata     = '0;
        mHoldKnown = 1'b1;
        mCnt       = 0;
    endtask

    function automatic bit waitingHit(input bit v, input bit won, input logic [AW-1:0] a,
                                      input bit e, input logic [AW-1:0] ra);
        return e && (ra != 0) && v && !won && (a == ra);
    endfunction

    // Drives one cycle of inputs (at posedge+1), checks at negedge, advances the model, returns the winner.
    task automatic applyStimulus(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input bit e1, input logic [AW-1:0] r1,
                                 input bit e2, input logic [AW-1:0] r2,
                                 output int winner);
        bit expStall;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        re1 = e1; raddr1 = r1; re2 = e2; raddr2 = r2;

        if (v0 && v1)  winner = mPrefer;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
        else           winner = -1;

        expStall = waitingHit(v0, winner == 0, a0, e1, r1) || waitingHit(v1, winner == 1, a1, e1, r1) ||
                   waitingHit(v0, winner == 0, a0, e2, r2) || waitingHit(v1, winner == 1, a1, e2, r2);

        @(negedge clk);
        checkOutput("req0_ready", 64'(req0_ready), 64'(winner == 0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(winner == 1));
        checkOutput("stall_o", 64'(stall_o), 64'(expStall));
        checkOutput("we_o", 64'(we_o), 64'(mWe));
        if (mWe || mHoldKnown) begin
            checkOutput("waddr_o", 64'(waddr_o), 64'(mWaddr));
            checkOutput("wdata_o", 64'(wdata_o), 64'(mWdata));
        end
`ifdef CANDY_WB_CONFLICT_CNT_EN
        checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(mCnt));
`endif

        if (winner >= 0) begin
            logic [AW-1:0] wa;
            wa = (winner == 1) ? a1 : a0;
            mWe = (wa != 0);
            if (wa != 0) begin
                mWaddr     = wa;
                mWdata     = (winner == 1) ? d1 : d0;
                mHoldKnown = 1'b1;
            end else begin
                mHoldKnown = 1'b0;
            end
            mPrefer = 1 - winner;
        end else begin
            mWe = 1'b0;
        end
        if (v0 && v1 && mCnt < (2 ** CW) - 1) mCnt++;

        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        checkOutput("rst_we_o", 64'(we_o), 64'd0);
        checkOutput("rst_waddr_o", 64'(waddr_o), 64'd0);
        checkOutput("rst_wdata_o", 64'(wdata_o), 64'd0);
`ifdef CANDY_WB_CONFLICT_CNT_EN
        checkOutput("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
        modelReset();
        req0_valid = 1'b0; req1_valid = 1'b0; re1 = 1'b0; re2 = 1'b0;
        p0v = 1'b0; p1v = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rst = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        #12;
        doReset();

        // Idle, then single request and its write.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, w);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Contention from a fresh pointer, then alternation.
        doReset();
        applyStimulus(1, 5'd5, 32'h11, 1, 5'd7, 32'h22, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd6, 32'h33, 1, 5'd7, 32'h22, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd6, 32'h33, 1, 5'd8, 32'h44, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd10, 32'h55, 1, 5'd8, 32'h44, 0, 0, 0, 0, w);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Same address from both sides: the loser's value lands last.
        doReset();
        applyStimulus(1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 0, 0, 0, 0, w);
        applyStimulus(0, 0, 0, 1, 5'd9, 32'hB, 0, 0, 0, 0, w);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Hazard against a waiting req1, cleared on its grant; r0 reads never stall.
        doReset();
        applyStimulus(1, 5'd2, 32'h1, 1, 5'd4, 32'h55, 1, 5'd4, 0, 0, w);
        applyStimulus(0, 0, 0, 1, 5'd4, 32'h55, 1, 5'd4, 0, 0, w);
        applyStimulus(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 1, 5'd0, 1, 5'd0, w);

        // r0 write is accepted but not enabled; three contention cycles for the counter.
        doReset();
        applyStimulus(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd3, 32'h3, 1, 5'd2, 32'h2, 0, 0, 0, 0, w);
        applyStimulus(1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 0, 0, 0, 0, w);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Random traffic with small address space to provoke collisions and hazards.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            if (!p0v && $urandom_range(0, 99) < 60) begin
                p0v = 1'b1; p0a = AW'($urandom_range(0, 7)); p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 99) < 60) begin
                p1v = 1'b1; p1a = AW'($urandom_range(0, 7)); p1d = $urandom;
            end
            applyStimulus(p0v, p0a, p0d, p1v, p1a, p1d,
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), w);
            if (w == 0) p0v = 1'b0;
            if (w == 1) p1v = 1'b0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/candy_wb_arbiter.md
Name: candy_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 is the ALU path, requester 1 is the load/multi-cycle path.
- Arbitrates each cycle using round-robin and registers the winning write into the register file's we/waddr/wdata inputs.
- Also produces read-hazard stall signals for decode, so a source register with a queued, not-yet-written result is never read stale.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- CNT_W, 16, conflict counter width (used only when the optional feature is compiled in)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted)
- req0_valid  in  1  ALU writeback request
- req0_addr  in  ADDR_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  grant/accept, combinational
- req1_valid  in  1  load/multi-cycle writeback request
- req1_addr  in  ADDR_W  destination register
- req1_data  in  DATA_W  write data
- req1_ready  out  1  grant/accept, combinational
- we_o  out  1  register-file write enable, registered
- waddr_o  out  ADDR_W  register-file write address, registered
- wdata_o  out  DATA_W  register-file write data, registered
- re1, raddr1  in  1, ADDR_W  decode read port 1 query
- re2, raddr2  in  1, ADDR_W  decode read port 2 query
- stall_o  out  1  read hazard against a queued request
- conflict_cnt  out  CNT_W  only with CANDY_WB_CONFLICT_CNT_EN

Behaviour:
- Reset (rst=0, async): we_o=0, waddr_o=0, wdata_o=0; round-robin pointer rr=0 (requester 0 preferred); conflict_cnt=0.
- Handshake: a transfer occurs on a cycle with valid&ready. A requester holds valid, addr and data stable until ready is seen. ready never asserts without valid.
- Arbitration, single requester valid: that requester is granted.
- Arbitration, both valid: the requester selected by rr wins; the loser's ready=0.
- rr update: after any transfer, rr points to the requester that did not win. With no transfer, rr holds.
- Latency: the grant in cycle N appears on we_o/waddr_o/wdata_o in cycle N+1. The register file's same-cycle bypass covers reads in N+1.
- Cycles with no transfer: we_o=0; waddr_o and wdata_o hold their previous values.
- Address 0: the request is accepted (ready=1) and rr advances, but we_o=0 for that slot.
- Same address from both requesters in one cycle: the winner writes first and the loser writes the following cycle, so the loser's value is final. This is the intended ordering; no merge is performed.
- stall_o is combinational. It is 1 iff, for some read port k with rek=1 and raddrk!=0, some reqj_valid=1 with reqj_ready=0 and reqj_addr==raddrk.
- A request granted in the current cycle does not stall, because its write is bypassed next cycle.
- Reset mid-operation: registered outputs clear immediately. Requesters must re-present pending requests after reset deasserts.

Optional Feature:
- Macro: CANDY_WB_CONFLICT_CNT_EN.
- Defined: conflict_cnt increments by 1 on every cycle where both requesters are valid, saturating at all-ones. It resets to 0.
- Undefined: the conflict_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines: ADDR_W/DATA_W defaults, which reuse the existing register-address and register-width macros, and the zero address/zero word constants.
- The round-robin pointer and grant logic form one natural sub-module, candy_rr_arb2: inputs valid[1:0] and advance, outputs grant[1:0].

Test Plan:
- Reset: with rst=0, we_o=0, waddr_o=0, wdata_o=0 and conflict_cnt=0. After release, with no valid request, we_o stays 0.
- Single request: req0 {addr 3, data 0xDEADBEEF} -> req0_ready=1 that cycle; next cycle we_o=1, waddr_o=3, wdata_o=0xDEADBEEF.
- Contention, starting from rr=0, both requesters held valid:
  - cycle 1: req0 {5, 0x11}, req1 {7, 0x22} -> grant req0; cycle 2 output {5, 0x11}.
  - cycle 2: req0 {6, 0x33} -> grant req1; cycle 3 output {7, 0x22}.
  - Grants alternate thereafter.
- Same address: both requesters target addr 9 (req0 data 0xA, req1 data 0xB), rr=0 -> writes 0xA then 0xB on consecutive cycles.
- Hazard: req1 {4, 0x55} stalled behind req0, with re1=1 and raddr1=4 -> stall_o=1. On req1's grant cycle stall_o=0. With raddr1=0, stall_o=0.
- r0 write: req0 {0, 0xFFFFFFFF} -> ready=1, we_o stays 0. With CANDY_WB_CONFLICT_CNT_EN defined, 3 contention cycles give conflict_cnt=3.
